// File: rtl/capture_ctrl_if.sv
// Bundles the capture-engine control inputs and the buffer-write/status outputs.
// The slave side belongs to the engine; the master side drives arm/abort and the sample strobe.
interface capture_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              arm;
    logic              abort;
    logic              sample_valid;
    logic              trig_in;
    logic [ADDR_W-1:0] pretrig_len;
    logic [ADDR_W-1:0] posttrig_len;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;

    modport slave (
        input  arm, abort, sample_valid, trig_in, pretrig_len, posttrig_len,
        output buf_wr_en, buf_wr_addr, busy, done, trig_addr, start_addr
    );

    modport master (
        output arm, abort, sample_valid, trig_in, pretrig_len, posttrig_len,
        input  buf_wr_en, buf_wr_addr, busy, done, trig_addr, start_addr
    );
endinterface

// File: rtl/capture_ctrl.sv
// Circular pre/post-trigger write sequencer for the sample buffer; buf_wr_en is zero-latency from sample_valid.
// No backpressure: every valid sample while capturing is written, abort kills the write in the same cycle.
module capture_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic          wr_clk,
    input  logic          rst_n,
    capture_ctrl_if.slave cap
);
    typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] pre_l_q, pre_l_d;
    logic [ADDR_W-1:0] post_l_q, post_l_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              hist_q, hist_d;

    logic              capturing;
    logic              wr_en;
    logic              edge_det;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] post_clamp;

    assign capturing = (state_q == PRETRIG) || (state_q == WAIT_TRIG) || (state_q == POSTTRIG);
    assign wr_en     = capturing && cap.sample_valid && !cap.abort;
    assign edge_det  = wr_en && cap.trig_in && !hist_q;
    assign cnt_inc   = cnt_q + ADDR_W'(1);
    // All-ones minus pretrig_len is its bitwise inverse: the room left after pre + trigger sample.
    assign post_clamp = (cap.posttrig_len > ~cap.pretrig_len) ? ~cap.pretrig_len : cap.posttrig_len;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        pre_l_d      = pre_l_q;
        post_l_d     = post_l_q;
        cnt_d        = cnt_q;
        hist_d       = hist_q;

        if (cap.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cap.arm) begin
                        pre_l_d  = cap.pretrig_len;
                        post_l_d = post_clamp;
                        addr_d   = '0;
                        cnt_d    = '0;
                        hist_d   = 1'b0;
                        state_d  = (cap.pretrig_len == '0) ? WAIT_TRIG : PRETRIG;
                    end
                end
                PRETRIG: begin
                    if (wr_en) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == pre_l_q) state_d = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (edge_det) begin
                        trig_addr_d  = addr_q;
                        start_addr_d = addr_q - pre_l_q;
                        cnt_d        = '0;
                        state_d      = (post_l_q == '0) ? DONE : POSTTRIG;
                    end
                end
                POSTTRIG: begin
                    if (wr_en) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == post_l_q) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // wr_en already excludes abort and idle states, so this never collides with the arm path.
        if (wr_en) begin
            addr_d = addr_q + ADDR_W'(1);
            hist_d = cap.trig_in;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            pre_l_q      <= '0;
            post_l_q     <= '0;
            cnt_q        <= '0;
            hist_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            pre_l_q      <= pre_l_d;
            post_l_q     <= post_l_d;
            cnt_q        <= cnt_d;
            hist_q       <= hist_d;
        end
    end

    assign cap.buf_wr_en   = wr_en;
    assign cap.buf_wr_addr = addr_q;
    assign cap.busy        = capturing;
    assign cap.done        = (state_q == DONE);
    assign cap.trig_addr   = trig_addr_q;
    assign cap.start_addr  = start_addr_q;
endmodule
